// File: rtl/cpu_leds_fader_pkg.sv
// rtl/cpu_leds_fader_pkg.sv - shared constants and helpers for the LED fader
package cpu_leds_fader_pkg;

    localparam int DEFAULT_PWM_BITS = 8;
    localparam int DEFAULT_STEP_DIV = 50000;

    // Full-scale brightness for a given PWM width
    function automatic int level_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/cpu_leds_fader_channel.sv
// rtl/cpu_leds_fader_channel.sv - one LED channel: brightness level and PWM output register
module cpu_leds_fader_channel
    import cpu_leds_fader_pkg::*;
#(
    parameter int PWM_BITS = DEFAULT_PWM_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                fade_en,
    input  logic                pattern,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(level_max(PWM_BITS));

    logic [PWM_BITS-1:0] level;

    // Saturating ramp toward the pattern bit on each tick; bypass snaps to the rail
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
        end else if (!fade_en) begin
            level <= pattern ? MAX : '0;
        end else if (tick) begin
            if (pattern && (level != MAX)) begin
                level <= level + 1'b1;
            end else if (!pattern && (level != '0)) begin
                level <= level - 1'b1;
            end
        end
    end

    // Registered drive: pass-through in bypass, solid at the rails, PWM compare between
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led <= 1'b0;
        end else if (!fade_en) begin
            led <= pattern;
        end else if (level == '0) begin
            led <= 1'b0;
        end else if (level == MAX) begin
            led <= 1'b1;
        end else begin
            led <= (pwm_cnt < level);
        end
    end

endmodule

// File: rtl/cpu_leds_fader.sv
// rtl/cpu_leds_fader.sv - PWM fader between the LED PIO and the board LEDs
module cpu_leds_fader
    import cpu_leds_fader_pkg::*;
#(
    parameter int NUM_LEDS = 7,
    parameter int PWM_BITS = DEFAULT_PWM_BITS,
    parameter int STEP_DIV = DEFAULT_STEP_DIV
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic                fade_en,
    output logic [NUM_LEDS-1:0] led_out
);

    localparam int PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRESC_W-1:0]  presc;
    logic                tick;

    // With STEP_DIV of 1 the prescaler sits at 0 and tick is permanently high
    assign tick = (presc == PRESC_LAST);

    // Shared free-running PWM counter and fade-step prescaler
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            presc   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            presc   <= tick ? '0 : presc + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        cpu_leds_fader_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick),
            .pwm_cnt (pwm_cnt),
            .fade_en (fade_en),
            .pattern (pattern_in[i]),
            .led     (led_out[i])
        );
    end

endmodule

// File: tb/tb_cpu_leds_fader.sv
// tb/tb_cpu_leds_fader.sv - randomized self-checking bench for cpu_leds_fader
module tb_cpu_leds_fader;

    localparam int N   = 7;
    localparam int PB  = 4;
    localparam int MX  = 15;
    localparam int SD  = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] pattern_in = '0;
    logic         fade_en = 1'b1;
    logic [N-1:0] led_out;
    logic [N-1:0] led_fast;
    logic [N-1:0] led_slow;

    always #5 clk = ~clk;

    cpu_leds_fader #(.NUM_LEDS(N), .PWM_BITS(PB), .STEP_DIV(SD)) dut (
        .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .fade_en(fade_en), .led_out(led_out)
    );

    cpu_leds_fader #(.NUM_LEDS(N), .PWM_BITS(PB), .STEP_DIV(1)) dut_fast (
        .clk(clk), .reset_n(reset_n), .pattern_in(7'h7F), .fade_en(1'b1), .led_out(led_fast)
    );

    cpu_leds_fader #(.NUM_LEDS(N), .PWM_BITS(PB), .STEP_DIV(64)) dut_slow (
        .clk(clk), .reset_n(reset_n), .pattern_in(7'h7F), .fade_en(1'b1), .led_out(led_slow)
    );

    logic [PB-1:0] obs_level [N];
    logic [PB-1:0] fast_level;
    for (genvar gi = 0; gi < N; gi++) begin : g_obs
        assign obs_level[gi] = dut.g_chan[gi].u_chan.level;
    end
    assign fast_level = dut_fast.g_chan[0].u_chan.level;

    int vectors = 0;
    int errors  = 0;

    // Reference state: clocks since reset, per-channel brightness, expected LEDs
    int       n = 0;
    int       since_rst = 0;
    bit       first_epoch = 1'b1;
    int       mlvl [N];
    bit [N-1:0] mled = '0;
    int       slow_ones = 0;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        since_rst = 0;
        mled = '0;
        for (int i = 0; i < N; i++) mlvl[i] = 0;
    endtask

    // One clock: predict from current inputs, advance, compare outputs and levels
    task automatic step();
        int pwm;
        bit tk;
        int nl [N];
        bit [N-1:0] nled;
        tk  = (n % SD) == SD - 1;
        pwm = n % (MX + 1);
        for (int i = 0; i < N; i++) begin
            if (!fade_en) begin
                nled[i] = pattern_in[i];
                nl[i]   = pattern_in[i] ? MX : 0;
            end else begin
                if (mlvl[i] == 0)       nled[i] = 1'b0;
                else if (mlvl[i] == MX) nled[i] = 1'b1;
                else                    nled[i] = (pwm < mlvl[i]);
                nl[i] = mlvl[i];
                if (tk) begin
                    if (pattern_in[i]) nl[i] = (mlvl[i] < MX) ? mlvl[i] + 1 : MX;
                    else               nl[i] = (mlvl[i] > 0) ? mlvl[i] - 1 : 0;
                end
            end
        end
        @(posedge clk);
        #1;
        n++;
        since_rst++;
        mled = nled;
        for (int i = 0; i < N; i++) mlvl[i] = nl[i];
        check("led_out", int'(led_out), int'(mled));
        for (int i = 0; i < N; i++) check($sformatf("level%0d", i), int'(obs_level[i]), mlvl[i]);
        if (first_epoch) begin
            if (since_rst <= 20)
                check("fast_level", int'(fast_level), (since_rst < MX) ? since_rst : MX);
            if (since_rst >= 16 && since_rst <= 20)
                check("fast_led", int'(led_fast), 'h7F);
            if (since_rst >= 530 && since_rst <= 545)
                slow_ones += int'(led_slow[0]);
            if (since_rst == 545)
                check("duty_level8", slow_ones, 8);
        end
    endtask

    task automatic reset_now();
        reset_n = 1'b0;
        #1;
        check("rst_led", int'(led_out), 0);
        for (int i = 0; i < N; i++) check($sformatf("rst_level%0d", i), int'(obs_level[i]), 0);
        model_reset();
    endtask

    task automatic release_now();
        reset_n = 1'b1;
        #1;
        check("rst_pwm", int'(dut.pwm_cnt), 0);
    endtask

    initial begin
        int bound;
        model_reset();
        pattern_in = 7'h7F;
        fade_en    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_now();
        release_now();

        // Fade up from reset; slow instance gets its duty window along the way
        for (int k = 1; k <= 560; k++) begin
            step();
            if (k == 59) check("up_59", int'(obs_level[0]), 14);
            if (k == 60) check("up_60", int'(obs_level[0]), MX);
        end

        // Fade down and stay saturated at 0
        pattern_in = 7'h00;
        for (int k = 1; k <= 70; k++) begin
            step();
            if (k == 59) check("down_59", int'(obs_level[0]), 1);
            if (k == 60 || k == 70) check("down_sat", int'(obs_level[0]), 0);
        end

        // Reversal of channel 0 at level 6
        pattern_in = 7'h7F;
        bound = 0;
        while (mlvl[0] != 6 && bound < 100) begin
            step();
            bound++;
        end
        check("rev_reach6", mlvl[0], 6);
        pattern_in = 7'h7E;
        bound = 0;
        while (mlvl[0] == 6 && bound < 10) begin
            step();
            bound++;
        end
        check("rev_ch0", int'(obs_level[0]), 5);
        check("rev_ch1", int'(obs_level[1]), 7);

        // Asynchronous reset in the middle of a ramp
        pattern_in = 7'h7F;
        repeat ($urandom_range(5, 30)) step();
        #2;
        first_epoch = 1'b0;
        reset_now();
        @(posedge clk);
        #1;
        release_now();
        repeat (70) step();
        check("rerampt_full", int'(obs_level[3]), MX);

        // Bypass then resume fading from the snapped levels
        fade_en    = 1'b0;
        pattern_in = 7'h55;
        step();
        check("bypass_led", int'(led_out), 'h55);
        fade_en    = 1'b1;
        pattern_in = 7'h2A;
        repeat (80) step();
        check("resume_ch0", int'(obs_level[0]), 0);
        check("resume_ch1", int'(obs_level[1]), MX);

        // Random pattern writes and occasional bypass toggles
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) pattern_in = N'($urandom);
            if ($urandom_range(0, 31) == 0) fade_en = ~fade_en;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cpu_leds_fader.md
# cpu_leds_fader

Output conditioner directly downstream of the 7-bit LED PIO. It consumes the PIO's `out_port` pattern, which is static between CPU writes, and drives the board LEDs. Each LED ramps its brightness smoothly toward on or off through a per-channel PWM level instead of switching hard. A bypass input restores direct pass-through.

## Interface
Parameters:
- `NUM_LEDS`, default 7: number of LED channels; matches the PIO width.
- `PWM_BITS`, default 8: width of the PWM counter and of each brightness level. MAX = 2^PWM_BITS−1.
- `STEP_DIV`, default 50000: clocks per fade step. Legal range is ≥1; 1 means a step every clock.

Ports:
- `clk`, in, 1: single system clock. All state is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `pattern_in`, in, NUM_LEDS: target pattern from the PIO `out_port`; same clock domain, no synchronizer.
- `fade_en`, in, 1: 1 = fading active; 0 = bypass.
- `led_out`, out, NUM_LEDS: registered LED drive.

## Operation
- **pwm_cnt:** free-running PWM_BITS counter.
  - Increments every clock.
  - Wraps MAX→0.
- **Prescaler:** counts 0..STEP_DIV−1.
  - `tick` is a 1-clock pulse in the cycle where the prescaler equals STEP_DIV−1.
  - The prescaler returns to 0 on the next clock.
- **level[i]:** per-channel brightness, PWM_BITS wide.
  - With fade_en=1 and tick=1:
    - pattern_in[i]=1 and level<MAX: level+1.
    - pattern_in[i]=0 and level>0: level−1.
    - Otherwise hold. Level saturates and never wraps.
  - With fade_en=1 and tick=0: level holds.
  - With fade_en=0: every clock, level[i] is loaded with MAX if pattern_in[i]=1, else 0. The prescaler keeps running.
- **led_out[i] next value:**
  - fade_en=0: pattern_in[i].
  - level=0: 0.
  - level=MAX: 1. Full-on is a solid drive, not a 255/256 duty.
  - Otherwise: (pwm_cnt < level). Duty cycle is level/2^PWM_BITS.
- **Direction reversal:** a pattern change mid-ramp reverses direction from the current level on the next tick. There is no restart.
- **fade_en 0→1:** ramping resumes from the snapped level (0 or MAX). There is no visible glitch.

## Timing
- **Reset values:** pwm_cnt, prescaler, all levels and led_out are 0. led_out is therefore all LEDs off.
- **Reset mid-ramp:** applying reset during a ramp immediately zeroes everything asynchronously. After release, all channels ramp up from 0 if the pattern bits are 1.
- **Compare path latency:** led_out is registered and reflects pwm_cnt/level from the previous cycle, so latency is 1 clock.
- **Bypass latency:** pattern_in→led_out takes exactly 1 clock.
- **Tick-to-level latency:** a tick in cycle N updates level at the edge ending cycle N. led_out reflects the new level one cycle later.
- **Full ramp time:** a ramp 0→MAX takes MAX ticks = MAX·STEP_DIV clocks. The ramp down is symmetric.
- **Pattern vs tick timing:** pattern_in is sampled only on tick cycles (fade mode). A pattern change that arrives in the same cycle as a tick takes effect on that tick.
- **Simultaneous events:** fade_en=0 takes priority over tick in the same cycle.

## Structure
- **Shared package `cpu_leds_fader_pkg`:**
  - Function `level_max(PWM_BITS)`.
  - Default constants for PWM_BITS and STEP_DIV.
- **Sub-module `cpu_leds_fader_channel`:** one per LED, instantiated NUM_LEDS times via generate.
  - Contains the level register, the saturating up/down logic and the output comparator/register.
  - Takes tick, pwm_cnt, fade_en and its pattern bit.
- **Top level:** owns the single pwm_cnt and prescaler shared by all channels.

## Test plan
Bench parameters: PWM_BITS=4 (MAX=15), STEP_DIV=4.

- **Reset:** assert reset_n=0 mid-ramp → led_out=0 and levels=0 immediately, without waiting for a clock edge. After release, pwm_cnt restarts at 0.
- **Fade up:** pattern_in=7'h7F with fade_en=1 from reset → level reaches 15 after 60 clocks; led_out then stays solid 1. Expected duty is 8/16 at level 8; measure it over one 16-clock period.
- **Fade down with saturation:** start all at 15, set pattern_in=0 → level reaches 0 after 60 clocks and holds at 0. There is no wrap to 15 on further ticks.
- **Reversal:** switch channel 0 from 1 to 0 at level 6 → the next tick gives level 5. Channels 1–6 are unaffected.
- **Bypass:** fade_en=0 with pattern_in=7'h55 → led_out=7'h55 one clock later and all levels snap to 15 or 0. Then set fade_en=1 and pattern_in=7'h2A → bit0 starts ramping down from 15 and bit1 starts ramping up from 0.
- **STEP_DIV=1 corner:** tick is asserted every clock → 0→15 completes in 15 clocks.
